// File: rtl/stream_fifo.sv
// Parametrised synchronous stream FIFO with occupancy count, almost-full/empty levels, flush and sticky error flags.
// Define FIFO_FWFT_EN for first-word-fall-through output; default is a registered read port.
module stream_fifo #(
  parameter int DEPTH        = 4,
  parameter int DATA_WIDTH   = 8,
  parameter int AFULL_LEVEL  = DEPTH - 1,
  parameter int AEMPTY_LEVEL = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clear,
  input  logic                       w_en,
  input  logic [DATA_WIDTH-1:0]      data_in,
  input  logic                       r_en,
  output logic [DATA_WIDTH-1:0]      data_out,
  output logic                       full,
  output logic                       empty,
  output logic                       almost_full,
  output logic                       almost_empty,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] LAST_PTR   = PW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]         w_ptr;
  logic [PW-1:0]         r_ptr;
  logic                  rd;
  logic                  wr;

  // Explicit wrap so non-power-of-two depths use every entry.
  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  // Flags decode the count register only, so no combinational path from w_en/r_en.
  assign full         = (count == FULL_COUNT);
  assign empty        = (count == '0);
  assign almost_full  = (int'(count) >= AFULL_LEVEL);
  assign almost_empty = (int'(count) <= AEMPTY_LEVEL);

  // A push into a full FIFO is taken when a pop frees a slot in the same cycle.
  assign rd = r_en & ~empty;
  assign wr = w_en & (~full | rd);

  // NOTE: storage has no reset; only control state needs a known value, and leaving the array unreset lets it map onto RAM.
  always_ff @(posedge clk) begin
    if (wr && !clear) mem[w_ptr] <= data_in;
  end

  // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_ptr     <= '0;
      r_ptr     <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (clear) begin
      w_ptr     <= '0;
      r_ptr     <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr) w_ptr <= next_ptr(w_ptr);
      if (rd) r_ptr <= next_ptr(r_ptr);
      case ({wr, rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (w_en && !wr) overflow  <= 1'b1;
      if (r_en && !rd) underflow <= 1'b1;
    end
  end

`ifdef FIFO_FWFT_EN
  // Head of queue is visible with zero latency; r_en only retires it.
  assign data_out = empty ? '0 : mem[r_ptr];
`else
  // Registered read port: holds between pops and across a flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out <= '0;
    end else if (rd && !clear) begin
      data_out <= mem[r_ptr];
    end
  end
`endif

endmodule

// File: tb/tb_stream_fifo.sv
// Scoreboard bench for stream_fifo (DEPTH=5): queue-based reference model, randomized and directed traffic.
module tb_stream_fifo;

  localparam int DEPTH = 5;
  localparam int DW    = 8;
  localparam int AFL   = 3;
  localparam int AEL   = 1;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clear = 1'b0;
  logic          w_en = 1'b0;
  logic          r_en = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic [DW-1:0] data_out;
  logic          full, empty, almost_full, almost_empty, overflow, underflow;
  logic [CW-1:0] count;

  int errors = 0;
  int checks = 0;

  logic [DW-1:0] model_q[$];
  logic [DW-1:0] exp_q[$];
  bit            m_ovf = 1'b0;
  bit            m_udf = 1'b0;
  bit            exp_pop = 1'b0;
  logic [DW-1:0] last_out = '0;

  stream_fifo #(
    .DEPTH(DEPTH), .DATA_WIDTH(DW), .AFULL_LEVEL(AFL), .AEMPTY_LEVEL(AEL)
  ) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .w_en(w_en), .data_in(data_in),
    .r_en(r_en), .data_out(data_out), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_state(input string tag);
    int n;
    n = model_q.size();
    check({tag, " count"}, 32'(count), n);
    check({tag, " empty"}, 32'(empty), (n == 0) ? 1 : 0);
    check({tag, " full"}, 32'(full), (n == DEPTH) ? 1 : 0);
    check({tag, " almost_full"}, 32'(almost_full), (n >= AFL) ? 1 : 0);
    check({tag, " almost_empty"}, 32'(almost_empty), (n <= AEL) ? 1 : 0);
    check({tag, " overflow"}, 32'(overflow), 32'(m_ovf));
    check({tag, " underflow"}, 32'(underflow), 32'(m_udf));
  endtask

  task automatic check_reset(input string tag);
    check({tag, " count"}, 32'(count), 0);
    check({tag, " empty"}, 32'(empty), 1);
    check({tag, " full"}, 32'(full), 0);
    check({tag, " almost_empty"}, 32'(almost_empty), 1);
    check({tag, " almost_full"}, 32'(almost_full), 0);
    check({tag, " overflow"}, 32'(overflow), 0);
    check({tag, " underflow"}, 32'(underflow), 0);
    check({tag, " data_out"}, 32'(data_out), 0);
  endtask

  // One clock of stimulus; the model decides acceptance from occupancy alone.
  task automatic step(input bit clr, input bit we, input bit re, input logic [DW-1:0] din);
    bit rd, wr;
    @(negedge clk);
    clear = clr; w_en = we; r_en = re; data_in = din;
    rd = re && (model_q.size() > 0);
    wr = we && ((model_q.size() < DEPTH) || rd);
    exp_pop = rd && !clr;
    if (exp_pop) exp_q.push_back(model_q[0]);
    @(posedge clk);
    if (clr) begin
      model_q.delete();
      m_ovf = 1'b0;
      m_udf = 1'b0;
    end else begin
      if (rd) void'(model_q.pop_front());
      if (wr) model_q.push_back(din);
      if (we && !wr) m_ovf = 1'b1;
      if (re && !rd) m_udf = 1'b1;
    end
    #1 check_state("step");
  endtask

  // Monitor: compares read data against the scoreboard whenever a pop was accepted.
  initial forever begin
`ifdef FIFO_FWFT_EN
    @(negedge clk); #2;
    if (exp_pop) begin
      if (exp_q.size() == 0) check("scoreboard underrun", 1, 0);
      else check("fwft head", 32'(data_out), 32'(exp_q.pop_front()));
    end else if (model_q.size() == 0) begin
      check("fwft empty data", 32'(data_out), 0);
    end
`else
    @(posedge clk); #2;
    if (exp_pop) begin
      if (exp_q.size() == 0) check("scoreboard underrun", 1, 0);
      else begin
        last_out = exp_q.pop_front();
        check("read data", 32'(data_out), 32'(last_out));
      end
    end else begin
      check("hold data", 32'(data_out), 32'(last_out));
    end
`endif
  end

  initial begin
    #2 check_reset("reset");
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 1'b0, 8'(8'h11 + i));
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b1, 8'h00);

    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0, 8'(8'h31 + i));
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, 8'(8'h41 + i));
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b1, 8'h00);

    step(1'b0, 1'b1, 1'b1, 8'hA5);
    step(1'b0, 1'b0, 1'b1, 8'h00);

    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 8'(8'h51 + i));
    step(1'b1, 1'b1, 1'b0, 8'h77);
    step(1'b0, 1'b0, 1'b0, 8'h00);

    for (int i = 0; i < 300; i++) begin
      int wp;
      wp = (i < 150) ? 70 : 35;
      step(1'($urandom_range(15) == 0),
           1'($urandom_range(99) < wp),
           1'($urandom_range(99) < 100 - wp),
           8'($urandom));
    end

    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 8'(8'h61 + i));
    step(1'b0, 1'b1, 1'b1, 8'h64);
    #2;
    exp_pop = 1'b0;
    rst_n = 1'b0;
    #1 check_reset("async reset");
    model_q.delete();
    exp_q.delete();
    m_ovf = 1'b0;
    m_udf = 1'b0;
    last_out = '0;
    clear = 1'b0; w_en = 1'b0; r_en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 40; i++)
      step(1'b0, 1'($urandom_range(1)), 1'($urandom_range(1)), 8'($urandom));
    step(1'b0, 1'b0, 1'b0, 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
